// File: rtl/log2_share_pkg.sv
// Shared constants, tag type and operand helpers for the shared log2 scheduler.
// The log2 input is 16.8 unsigned fixed point, and the output is 4.8.
package log2_share_pkg;

  localparam int LOG2_IN_W  = 24;
  localparam int LOG2_OUT_W = 12;
  localparam logic [LOG2_IN_W-1:0] LOG2_MIN_IN = 24'h000100;

  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                uf;
  } log2_tag_t;

  function automatic logic is_underflow(input logic [LOG2_IN_W-1:0] d);
    return d < LOG2_MIN_IN;
  endfunction

  function automatic logic [LOG2_IN_W-1:0] clamp_operand(input logic [LOG2_IN_W-1:0] d);
    return is_underflow(d) ? LOG2_MIN_IN : d;
  endfunction

endpackage

// File: rtl/log2_share_ctrl_rr_grant.sv
// Combinational round-robin arbiter. It returns a one-hot grant to the first set req at or after ptr.
// The module has zero latency. It keeps no state, so the caller owns the pointer.
module rr_grant
  import log2_share_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [N-1:0] req_rot;
  logic [N-1:0] gnt_rot;

  // The requests are rotated so that ptr lands on bit 0. The lowest set bit is picked, then rotated back.
  always_comb begin
    req_rot = N'({req, req} >> ptr);
    gnt_rot = req_rot & (~req_rot + N'(1));
    gnt     = N'(({gnt_rot, gnt_rot} << ptr) >> N);
  end

endmodule

// File: rtl/log2_share_ctrl.sv
// Round-robin time-share of one fixed-latency log2 core. Each result returns LATENCY+1 cycles after its accept.
// Grants wait for en, and one op per cycle is sustained. Results have no backpressure, and each is a one-cycle strobe.
module log2_share_ctrl
  import log2_share_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*LOG2_IN_W-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [LOG2_IN_W-1:0]       log_din,
  input  logic [LOG2_OUT_W-1:0]      log_dout,
  output logic [N_REQ-1:0]           res_valid,
  output logic [LOG2_OUT_W-1:0]      res_data,
  output logic                       res_underflow,
  output logic                       busy
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gnt_ptr;
  logic [N_REQ-1:0]     req_masked;
  logic [N_REQ-1:0]     gnt;
  logic                 grant;
  logic [LOG2_IN_W-1:0] sel_data;
  log2_tag_t            tag_q [LATENCY+1];
  log2_tag_t            tag_last;

  assign req_masked = req_valid & {N_REQ{en}};

  rr_grant #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_grant (
    .req (req_masked),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // The grant is forced to zero during reset, so no accept edge can occur while state is cleared.
  assign req_ready = gnt & {N_REQ{rst_n}};

  always_comb begin
    grant    = |req_ready;
    gnt_ptr  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        gnt_ptr  = PTR_W'(i);
        sel_data = req_data[i*LOG2_IN_W +: LOG2_IN_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      log_din <= LOG2_MIN_IN;
    end else if (grant) begin
      rr_ptr  <= (int'(gnt_ptr) == N_REQ - 1) ? '0 : gnt_ptr + PTR_W'(1);
      log_din <= clamp_operand(sel_data);
    end
  end

  // The tag shifts in lockstep with the core, so the last stage lines up with log_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0].valid <= grant;
      tag_q[0].id    <= TAG_ID_W'(gnt_ptr);
      tag_q[0].uf    <= grant & is_underflow(sel_data);
      for (int s = 1; s <= LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign tag_last = tag_q[LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid     <= '0;
      res_data      <= '0;
      res_underflow <= 1'b0;
    end else if (tag_last.valid) begin
      for (int i = 0; i < N_REQ; i++) begin
        res_valid[i] <= (tag_last.id == TAG_ID_W'(i));
      end
      res_data      <= tag_last.uf ? '0 : log_dout;
      res_underflow <= tag_last.uf;
    end else begin
      res_valid <= '0;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s <= LATENCY; s++) begin
      busy = busy | tag_q[s].valid;
    end
  end

endmodule

// File: tb/tb_log2_share_ctrl.sv
// Directed and scoreboarded bench for log2_share_ctrl, with a behavioural 3-stage log2 core.
// The core model is a piecewise-linear log2 whose top code is 0xFFD.
module tb_log2_share_ctrl;

  localparam int N   = 4;
  localparam int LAT = 3;

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] data;
    logic        uf;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  req_valid;
  logic [N*24-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [23:0]   log_din;
  logic [11:0]   log_dout;
  logic [N-1:0]  res_valid;
  logic [11:0]   res_data;
  logic          res_underflow;
  logic          busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  exp_t exp_q [$];
  logic [11:0] core_q [LAT];
  logic [11:0] exp_t2 [4] = '{12'h000, 12'h200, 12'h800, 12'hFFD};

  log2_share_ctrl #(.N_REQ(N), .LATENCY(LAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .log_din       (log_din),
    .log_dout      (log_dout),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_underflow (res_underflow),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] core_log2(input logic [23:0] x);
    int          p;
    logic [23:0] n;
    logic [11:0] r;
    p = -1;
    for (int b = 0; b < 24; b++) if (x[b]) p = b;
    if (p < 8) return 12'h000;
    n = x << (23 - p);
    r = {4'(p - 8), n[22:15]};
    return (r > 12'hFFD) ? 12'hFFD : r;
  endfunction

  always @(posedge clk) begin
    core_q[0] <= core_log2(log_din);
    for (int k = 1; k < LAT; k++) core_q[k] <= core_q[k-1];
  end
  assign log_dout = core_q[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [23:0] d);
    req_data[i*24 +: 24] = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = '0; en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic sb_retire();
    exp_t e;
    if (res_valid != '0) begin
      if (exp_q.size() == 0) check("sb_extra", 32'(res_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_id", 32'(res_valid), 32'(1) << e.id);
        check("sb_data", 32'(res_data), 32'(e.data));
        check("sb_uf", 32'(res_underflow), 32'(e.uf));
      end
    end
  endtask

  initial begin
    int           seen;
    logic [N-1:0] acc;
    logic [23:0]  d;
    exp_t         e;

    rst_n = 1'b1; en = 1'b1; req_valid = '0; req_data = '0;
    #2 rst_n = 1'b0; req_valid = 4'b0001; set_op(0, 24'h000200);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_log_din", 32'(log_din), 32'h100);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_uf", 32'(res_underflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; req_valid = '0;

    // Single op: same-cycle ready, then the result four edges after the accept.
    @(posedge clk); #1; req_valid = 4'b0001; set_op(0, 24'h000200);
    @(negedge clk); check("t1_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1; req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) check("t1_log_din", 32'(log_din), 32'h200);
      check("t1_busy", 32'(busy), (k <= 3) ? 32'd1 : 32'd0);
      check("t1_res_valid", 32'(res_valid), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) check("t1_res_data", 32'(res_data), 32'h100);
    end

    // Four persistent requesters rotate, and the results stream back to back.
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'hF;
    set_op(0, 24'h000100); set_op(1, 24'h000400); set_op(2, 24'h010000); set_op(3, 24'hFFFFFF);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < 8) check("t2_ready", 32'(req_ready), 32'(1) << (c % 4));
      if (c >= 5) check("t2_res_valid", 32'(res_valid), (c < 13) ? (32'(1) << ((c - 5) % 4)) : 32'd0);
      if (c >= 5 && c < 13) begin
        check("t2_res_data", 32'(res_data), 32'(exp_t2[(c - 5) % 4]));
        check("t2_uf", 32'(res_underflow), 32'd0);
      end
      @(posedge clk); #1;
      if (c == 7) req_valid = '0;
    end

    // An operand below 1.0 is clamped in flight, and its result is zero with the underflow flag set.
    req_valid = 4'b0100; set_op(2, 24'h000080);
    @(negedge clk); check("t3_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk); check("t3_log_din", 32'(log_din), 32'h100);
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("t3_res_valid", 32'(res_valid), 32'h4);
    check("t3_res_data", 32'(res_data), 32'h0);
    check("t3_uf", 32'(res_underflow), 32'd1);

    // en low blocks grants. Afterwards the pointer resumes from just past requester 0.
    @(posedge clk); #1; en = 1'b1; req_valid = 4'b0001; set_op(0, 24'h000300);
    @(negedge clk); check("t4_prep_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    en = 1'b0; req_valid = 4'b1010; set_op(1, 24'h000800); set_op(3, 24'h001000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("t4_en_low", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1; en = 1'b1;
    @(negedge clk); check("t4_grant1", 32'(req_ready), 32'h2);
    @(posedge clk); #1; req_valid = 4'b1000;
    @(negedge clk); check("t4_grant3", 32'(req_ready), 32'h8);
    @(posedge clk); #1; req_valid = '0;
    repeat (8) @(posedge clk);
    #1;

    // Reset lands while three ops are in flight, so none of them may retire.
    req_valid = 4'b0111;
    set_op(0, 24'h000200); set_op(1, 24'h000400); set_op(2, 24'h000800);
    @(negedge clk); check("t5_ready0", 32'(req_ready), 32'h1);
    @(posedge clk); #1; req_valid = 4'b0110;
    @(negedge clk); check("t5_ready1", 32'(req_ready), 32'h2);
    @(posedge clk); #1; req_valid = 4'b0100;
    @(posedge clk); #1; rst_n = 1'b0; req_valid = 4'b0110;
    @(negedge clk);
    check("t5_rst_ready", 32'(req_ready), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; req_valid = '0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (res_valid != '0 || busy) seen++;
    end
    check("t5_no_result", 32'(seen), 32'd0);
    check("t5_res_data", 32'(res_data), 32'd0);
    check("t5_uf", 32'(res_underflow), 32'd0);
    check("t5_log_din", 32'(log_din), 32'h100);
    @(posedge clk); #1; req_valid = 4'b0110; set_op(1, 24'h000200); set_op(2, 24'h000200);
    @(negedge clk); check("t5_first_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1; req_valid = 4'b0100;
    @(negedge clk); check("t5_second_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1; req_valid = '0;
    repeat (8) @(posedge clk);
    #1;

    // Random traffic is checked against the scoreboard.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      sb_retire();
      check("rnd_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          d      = req_data[i*24 +: 24];
          e.id   = 2'(i);
          e.uf   = (d < 24'h000100);
          e.data = e.uf ? 12'h000 : core_log2(d);
          exp_q.push_back(e);
          n_acc++;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && c < 270 && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          if ($urandom_range(0, 3) == 0) set_op(i, 24'($urandom_range(0, 255)));
          else set_op(i, 24'($urandom));
        end
      end
      en = (c >= 270) || ($urandom_range(0, 7) != 0);
    end
    check("sb_left", 32'(exp_q.size()), 32'd0);
    check("sb_idle", 32'({busy, req_valid}), 32'd0);
    check("sb_activity", 32'(n_acc > 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
